// File: rtl/led_fader.sv
// Four-channel PWM LED fader: each channel ramps linearly between off and fully on.
// Define LED_FADER_GAMMA_EN to map levels through a square-law curve before the PWM compare.
module led_fader #(
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 97656
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] pat_in,
    output logic [3:0] led_out,
    output logic       busy
);

    localparam int                  DIV_W    = $clog2(STEP_DIV);
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;
    localparam logic [PWM_BITS-1:0] LVL_PEN  = LVL_MAX - 1'b1;
    localparam logic [PWM_BITS-1:0] LVL_ONE  = PWM_BITS'(1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_RISE,
        ST_ON,
        ST_FALL
    } state_e;

    logic [3:0]          pat_q;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                tick;
    state_e              state_q [4];
    state_e              state_d [4];
    logic [PWM_BITS-1:0] lvl_q [4];
    logic [PWM_BITS-1:0] lvl_d [4];
    logic [3:0]          led_out_q, led_out_d;
    logic                busy_q, busy_d;

    function automatic logic [PWM_BITS-1:0] duty_of(input logic [PWM_BITS-1:0] lvl);
`ifdef LED_FADER_GAMMA_EN
        logic [2*PWM_BITS-1:0] wide;
        wide = {{PWM_BITS{1'b0}}, lvl};
        return PWM_BITS'((wide * wide) >> PWM_BITS);
`else
        return lvl;
`endif
    endfunction

    assign tick      = (div_q == DIV_LAST);
    assign div_d     = tick ? '0 : div_q + 1'b1;
    assign pwm_cnt_d = pwm_cnt_q + 1'b1;

    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // otherwise an unassigned path would infer a latch.
        busy_d    = 1'b0;
        led_out_d = '0;
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            lvl_d[i]   = lvl_q[i];
            // A direction change wins over a tick landing in the same cycle.
            unique case (state_q[i])
                ST_OFF: if (pat_q[i]) state_d[i] = ST_RISE;
                ST_RISE: begin
                    if (!pat_q[i]) begin
                        state_d[i] = ST_FALL;
                    end else if (tick) begin
                        if (lvl_q[i] != LVL_MAX) lvl_d[i] = lvl_q[i] + 1'b1;
                        if (lvl_q[i] >= LVL_PEN) state_d[i] = ST_ON;
                    end
                end
                ST_ON: if (!pat_q[i]) state_d[i] = ST_FALL;
                ST_FALL: begin
                    if (pat_q[i]) begin
                        state_d[i] = ST_RISE;
                    end else if (tick) begin
                        if (lvl_q[i] != '0) lvl_d[i] = lvl_q[i] - 1'b1;
                        if (lvl_q[i] <= LVL_ONE) state_d[i] = ST_OFF;
                    end
                end
                default: state_d[i] = ST_OFF;
            endcase

            led_out_d[i] = (state_q[i] == ST_ON) || (pwm_cnt_q < duty_of(lvl_q[i]));
            if (state_q[i] == ST_RISE || state_q[i] == ST_FALL) busy_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q     <= '0;
            pwm_cnt_q <= '0;
            div_q     <= '0;
            led_out_q <= '0;
            busy_q    <= 1'b0;
            // NOTE: the per-channel level array is reset too, so a reset
            // mid-fade never leaves a stale brightness behind.
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= ST_OFF;
                lvl_q[i]   <= '0;
            end
        end else begin
            pat_q     <= pat_in;
            pwm_cnt_q <= pwm_cnt_d;
            div_q     <= div_d;
            led_out_q <= led_out_d;
            busy_q    <= busy_d;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                lvl_q[i]   <= lvl_d[i];
            end
        end
    end

    assign led_out = led_out_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_led_fader.sv
// Scoreboard bench for led_fader with PWM_BITS=4, STEP_DIV=2: expectations are queued
// per scenario with the edge count they apply to, and a negedge monitor compares them.
module tb_led_fader;

    localparam int PWM_BITS = 4;
    localparam int STEP_DIV = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] pat_in = 4'b0000;
    logic [3:0] led_out;
    logic       busy;

    led_fader #(
        .PWM_BITS(PWM_BITS),
        .STEP_DIV(STEP_DIV)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pat_in (pat_in),
        .led_out(led_out),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        logic [3:0] led;
        logic       bsy;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   ecnt;

    // ecnt == n at the negedge following edge n-1 (edge 0 = first edge after release)
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expect_at(input int at, input logic [3:0] led, input logic bsy, input string name);
        exp_t e;
        e.at   = at;
        e.led  = led;
        e.bsy  = bsy;
        e.name = name;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].at <= ecnt) begin
                mon_e = exp_q.pop_front();
                if (mon_e.at < ecnt) begin
                    check({mon_e.name, " missed"}, 32'(ecnt), 32'(mon_e.at));
                end else begin
                    check({mon_e.name, " led"}, 32'(led_out), 32'(mon_e.led));
                    check({mon_e.name, " busy"}, 32'(busy), 32'(mon_e.bsy));
                end
            end
        end
    end

    task automatic goto(input int n);
        int guard = 0;
        while (ecnt < n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (ecnt != n) begin
            total++;
            bad++;
            $display("FAIL goto: at edge count %0d, wanted %0d", ecnt, n);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() > 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations never reached", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset(input string name);
        #1 rst_n = 1'b0;
        pat_in = 4'b0000;
        #1;
        check({name, " async led"}, 32'(led_out), 32'd0);
        check({name, " async busy"}, 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Toggle one channel every two cycles so each reversal lands on a tick: level holds.
    task automatic hold_toggle(input int ch, input int from, input int to);
        for (int n = from; n <= to; n++) begin
            goto(n);
            pat_in[ch] = (((n - from) / 2) % 2) == 1;
        end
    endtask

    initial begin
        do_reset("reset0");

`ifdef LED_FADER_GAMMA_EN
        // Gamma: level 8 held -> duty (64 >> 4) = 4 of 16
        for (int k = 32; k < 48; k++)
            expect_at(k + 1, (k < 36) ? 4'b0001 : 4'b0000, 1'b1, $sformatf("gamma k%0d", k));
        goto(2);
        pat_in = 4'b0001;
        hold_toggle(0, 20, 49);
        drain();
`else
        // Full rise on channel 0
        expect_at(4, 4'b0000, 1'b0, "rise pre");
        expect_at(5, 4'b0000, 1'b1, "rise busy up");
        expect_at(27, 4'b0001, 1'b1, "rise lvl11 pwm10");
        expect_at(28, 4'b0000, 1'b1, "rise lvl11 pwm11");
        expect_at(34, 4'b0001, 1'b1, "rise last");
        for (int n = 35; n <= 50; n++)
            expect_at(n, 4'b0001, 1'b0, $sformatf("rise on n%0d", n));
        goto(2);
        pat_in = 4'b0001;
        drain();

        // Duty: channel 1 held at level 5 -> 5 high cycles per 16
        do_reset("reset1");
        for (int k = 16; k < 32; k++)
            expect_at(k + 1, (k <= 20) ? 4'b0010 : 4'b0000, 1'b1, $sformatf("duty k%0d", k));
        goto(2);
        pat_in = 4'b0010;
        hold_toggle(1, 14, 33);
        drain();

        // Reversal on a tick: channel 2 at level 9
        do_reset("reset2");
        expect_at(23, 4'b0100, 1'b1, "rev lvl9 pwm6");
        expect_at(25, 4'b0100, 1'b1, "rev held pwm8");
        expect_at(26, 4'b0000, 1'b1, "rev held pwm9");
        expect_at(27, 4'b0000, 1'b1, "rev lvl8 pwm10");
        expect_at(33, 4'b0100, 1'b1, "rev lvl5 pwm0");
        expect_at(42, 4'b0000, 1'b1, "rev lvl1");
        for (int n = 43; n <= 46; n++)
            expect_at(n, 4'b0000, 1'b0, $sformatf("rev off n%0d", n));
        goto(2);
        pat_in = 4'b0100;
        goto(22);
        pat_in = 4'b0000;
        drain();

        // Independence: channels 1 and 3 together
        do_reset("reset3");
        expect_at(4, 4'b0000, 1'b0, "ind pre");
        expect_at(5, 4'b0000, 1'b1, "ind busy up");
        expect_at(27, 4'b1010, 1'b1, "ind pwm10");
        expect_at(28, 4'b0000, 1'b1, "ind pwm11");
        expect_at(34, 4'b1010, 1'b1, "ind last");
        expect_at(35, 4'b1010, 1'b0, "ind on");
        expect_at(36, 4'b1010, 1'b0, "ind on2");
        goto(2);
        pat_in = 4'b1010;
        drain();

        // Reset mid-fade: channel 0 rising at level 7
        do_reset("reset4");
        expect_at(19, 4'b0001, 1'b1, "mid lvl7 pwm2");
        goto(2);
        pat_in = 4'b0001;
        goto(19);
        drain();
        do_reset("midfade");
        expect_at(3, 4'b0000, 1'b0, "post idle a");
        expect_at(6, 4'b0000, 1'b0, "post idle b");
        expect_at(8, 4'b0000, 1'b0, "post pre");
        expect_at(9, 4'b0000, 1'b1, "post busy up");
        expect_at(17, 4'b0001, 1'b1, "post lvl4 pwm0");
        expect_at(26, 4'b0000, 1'b1, "post lvl8 pwm9");
        goto(6);
        pat_in = 4'b0001;
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
